// File: rtl/awgn_run_ctrl.sv
// awgn_run_ctrl: run sequencer for the awgn noise generator.
// Holds the generator in reset while seeds settle, waits out its pipeline
// latency, then captures num_samples outputs (tagged with a 1-based index)
// into a FIFO drained over a valid/ready stream. The generator cannot stall,
// so a capture into a full FIFO without a same-cycle pop is dropped and counted.
module awgn_run_ctrl #(
    parameter int W          = 16,
    parameter int DEPTH      = 16,
    parameter int LATENCY    = 8,
    parameter int RST_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [191:0]     seed_in,
    output logic             gen_rst,
    output logic [191:0]     gen_seed,
    input  logic [W-1:0]     gen_awgn,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = (LATENCY > RST_CYCLES) ? LATENCY : RST_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SEED_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] WARM_LAST = TW'(LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_WARM, S_RUN, S_DRAIN} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] idx;
        logic [W-1:0]     data;
    } entry_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q;
    logic [CNT_W-1:0] num_q;
    logic [191:0]     seed_q;
    logic [CNT_W-1:0] k_q;
    logic [CNT_W-1:0] ovf_q;
    logic             done_q;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt_q;
    entry_t           head;

    logic accept, flush, run, push, pop, full, drop, fifo_empty;

    assign fifo_empty = (cnt_q == '0);
    assign full       = (cnt_q == (AW+1)'(DEPTH));
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    assign push       = run && (!full || pop);
    assign drop       = run && full && !pop;
    assign busy       = (state_q != S_IDLE);
    // Both an accepted start and an abort of a live run empty the FIFO.
    assign flush      = accept || (abort && busy);

    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head.data : '0;
    assign out_idx  = out_valid ? head.idx  : '0;
    assign gen_seed = seed_q;
    assign ovf_cnt  = ovf_q;
    assign done     = done_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state, generator reset and capture enable; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        gen_rst = 1'b1;
        accept  = 1'b0;
        run     = 1'b0;
        unique case (state_q)
            S_IDLE:  if (start && !abort) begin
                         state_d = S_SEED;
                         accept  = 1'b1;
                     end
            S_SEED:  if (tmr_q == SEED_LAST) state_d = S_WARM;
            S_WARM:  begin
                         gen_rst = 1'b0;
                         if (tmr_q == WARM_LAST)
                             state_d = (num_q == '0) ? S_DRAIN : S_RUN;
                     end
            S_RUN:   begin
                         gen_rst = 1'b0;
                         run     = !abort;
                         if (k_q == num_q) state_d = S_DRAIN;
                     end
            S_DRAIN: if (fifo_empty) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort && busy) state_d = S_IDLE;
    end

    // Phase timer for SEED/WARM; restarts on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           tmr_q <= '0;
        else if (state_d != state_q)                       tmr_q <= '0;
        else if (state_q == S_SEED || state_q == S_WARM)   tmr_q <= tmr_q + 1'b1;
    end

    // Run parameters latched on an accepted start; overflow count cleared there too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q  <= '0;
            seed_q <= '0;
            ovf_q  <= '0;
        end else if (accept) begin
            num_q  <= num_samples;
            seed_q <= seed_in;
            ovf_q  <= '0;
        end else if (drop && ovf_q != '1) begin
            ovf_q  <= ovf_q + 1'b1;
        end
    end

    // Capture index: 1 on entering RUN, stops at num_q so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       k_q <= '0;
        else if (state_q == S_WARM && state_d == S_RUN) k_q <= CNT_W'(1);
        else if (run && k_q != num_q)                  k_q <= k_q + 1'b1;
    end

    // Registered done so it lands on the first IDLE cycle after DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_q <= 1'b0;
        else     done_q <= (state_q == S_DRAIN) && fifo_empty && !abort;
    end

    // FIFO storage; with full+pop the write lands on the slot being popped.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{idx: k_q, data: gen_awgn};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

endmodule
